// File: rtl/router_fsm_np_pkg.sv
// router_pkg: shared types and constants for the N-port packet-router controller.
//   router_state_t   : 4-bit controller state encoding
//   addr_w(n)        : header address field width for n output ports
//   ROUTER_MAX_PORTS : largest supported port count
package router_pkg;

  localparam int ROUTER_MAX_PORTS = 16;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    WAIT_TILL_EMPTY    = 4'd1,
    LOAD_FIRST_DATA    = 4'd2,
    LOAD_DATA          = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    LOAD_PARITY        = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } router_state_t;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/router_fsm_np_if.sv
// router_fsm_np_if: byte-stream / FIFO status inputs and state strobes of the
// router controller.
//   master : source side (drives stream and FIFO status, observes strobes)
//   slave  : controller side (router_fsm_np)
interface router_fsm_np_if
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = addr_w(NUM_PORTS)
);

  logic                 pkt_valid;
  logic [ADDR_W-1:0]    data_in;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 parity_done;
  logic                 low_pkt_valid;

  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 laf_state;
  logic                 full_state;
  logic                 rst_int_reg;
  logic                 write_enb_reg;
  logic                 busy;
  logic                 drop_state;
  logic                 pkt_drop;
  logic [ADDR_W-1:0]    dest_addr;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, drop_state, pkt_drop, dest_addr
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, drop_state, pkt_drop, dest_addr
  );

endinterface

// File: rtl/router_fsm_np_wait_timer.sv
// router_wait_timer: saturating up-counter used to bound the wait for an
// empty destination FIFO.
//   clock, reset : clock, async active-high reset
//   clr          : synchronous clear (priority over en)
//   en           : count enable
//   done         : count has reached LIMIT-1 (never asserted when LIMIT==0)
module router_wait_timer #(
  parameter int LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (LIMIT != 0) && (count == LAST);

endmodule

// File: rtl/router_fsm_np.sv
// router_fsm_np: control FSM for an N-output packet router. Decodes the
// header address, waits for the destination FIFO to drain (with timeout),
// sequences payload/parity loading and FIFO-full back-pressure, and drops
// packets with an invalid address or an expired wait.
//   clock, reset : clock, async active-high reset
//   bus          : stream/FIFO status in, state strobes and dest_addr out
//
// state              | meaning
// DECODE_ADDRESS     | idle / header byte decode
// WAIT_TILL_EMPTY    | destination FIFO not yet empty, bounded wait
// LOAD_FIRST_DATA    | header byte written
// LOAD_DATA          | payload bytes written
// FIFO_FULL_STATE    | destination full, stall source
// LOAD_AFTER_FULL    | write the byte held during the stall
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | parity compare in the register block
// DROP_PACKET        | discard bytes until pkt_valid falls
module router_fsm_np
  import router_pkg::*;
#(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = addr_w(NUM_PORTS),
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic           clock,
  input  logic           reset,
  router_fsm_np_if.slave bus
);

  if (NUM_PORTS < 2 || NUM_PORTS > ROUTER_MAX_PORTS) begin : g_bad_num_ports
    $error("router_fsm_np: NUM_PORTS out of range");
  end

  localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);

  router_state_t     state, state_nxt;
  logic [ADDR_W-1:0] dest_addr, dest_nxt;
  logic              addr_ok, dest_ok, soft_hit, wait_done;

  logic detect_add_r, lfd_state_r, ld_state_r, laf_state_r, full_state_r;
  logic rst_int_reg_r, write_enb_r, busy_r, drop_state_r, pkt_drop_r;

  // Range guards keep per-port lookups from indexing past NUM_PORTS when the
  // address field can encode more values than there are ports.
  assign addr_ok  = {1'b0, bus.data_in} < PORT_LIMIT;
  assign dest_ok  = {1'b0, dest_addr} < PORT_LIMIT;
  assign soft_hit = dest_ok && bus.soft_reset[dest_addr] && (state != DECODE_ADDRESS);

  router_wait_timer #(.LIMIT(WAIT_TIMEOUT)) u_wait_timer (
    .clock (clock),
    .reset (reset),
    .clr   (state != WAIT_TILL_EMPTY),
    .en    (state == WAIT_TILL_EMPTY),
    .done  (wait_done)
  );

  always_comb begin
    state_nxt = state;
    dest_nxt  = dest_addr;
    if (soft_hit) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (bus.pkt_valid) begin
            dest_nxt = bus.data_in;
            if (!addr_ok)                        state_nxt = DROP_PACKET;
            else if (bus.fifo_empty[bus.data_in]) state_nxt = LOAD_FIRST_DATA;
            else                                 state_nxt = WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (dest_ok && bus.fifo_empty[dest_addr]) state_nxt = LOAD_FIRST_DATA;
          else if (wait_done)                       state_nxt = DROP_PACKET;
        end
        LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
        LOAD_DATA: begin
          if (bus.fifo_full)       state_nxt = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) state_nxt = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!bus.fifo_full) state_nxt = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (bus.parity_done)        state_nxt = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) state_nxt = LOAD_PARITY;
          else                        state_nxt = LOAD_DATA;
        end
        LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state_nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        DROP_PACKET: begin
          if (!bus.pkt_valid) state_nxt = DECODE_ADDRESS;
        end
        default: state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  // Strobes are decoded from the next state and registered, so each one
  // is a clean flop output aligned with the state it names.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= DECODE_ADDRESS;
      dest_addr     <= '0;
      detect_add_r  <= 1'b1;
      lfd_state_r   <= 1'b0;
      ld_state_r    <= 1'b0;
      laf_state_r   <= 1'b0;
      full_state_r  <= 1'b0;
      rst_int_reg_r <= 1'b0;
      write_enb_r   <= 1'b0;
      busy_r        <= 1'b0;
      drop_state_r  <= 1'b0;
      pkt_drop_r    <= 1'b0;
    end else begin
      state         <= state_nxt;
      dest_addr     <= dest_nxt;
      detect_add_r  <= 1'b0;
      lfd_state_r   <= 1'b0;
      ld_state_r    <= 1'b0;
      laf_state_r   <= 1'b0;
      full_state_r  <= 1'b0;
      rst_int_reg_r <= 1'b0;
      write_enb_r   <= 1'b0;
      busy_r        <= 1'b0;
      drop_state_r  <= 1'b0;
      pkt_drop_r    <= (state_nxt == DROP_PACKET) && (state != DROP_PACKET);
      case (state_nxt)
        DECODE_ADDRESS:  detect_add_r <= 1'b1;
        WAIT_TILL_EMPTY: busy_r       <= 1'b1;
        LOAD_FIRST_DATA: begin
          lfd_state_r <= 1'b1;
          busy_r      <= 1'b1;
        end
        LOAD_DATA: begin
          ld_state_r  <= 1'b1;
          write_enb_r <= 1'b1;
        end
        FIFO_FULL_STATE: begin
          full_state_r <= 1'b1;
          busy_r       <= 1'b1;
        end
        LOAD_AFTER_FULL: begin
          laf_state_r <= 1'b1;
          busy_r      <= 1'b1;
          write_enb_r <= 1'b1;
        end
        LOAD_PARITY: begin
          busy_r      <= 1'b1;
          write_enb_r <= 1'b1;
        end
        CHECK_PARITY_ERROR: begin
          rst_int_reg_r <= 1'b1;
          busy_r        <= 1'b1;
        end
        DROP_PACKET: drop_state_r <= 1'b1;
        default: detect_add_r <= 1'b1;
      endcase
    end
  end

  assign bus.detect_add    = detect_add_r;
  assign bus.lfd_state     = lfd_state_r;
  assign bus.ld_state      = ld_state_r;
  assign bus.laf_state     = laf_state_r;
  assign bus.full_state    = full_state_r;
  assign bus.rst_int_reg   = rst_int_reg_r;
  assign bus.write_enb_reg = write_enb_r;
  assign bus.busy          = busy_r;
  assign bus.drop_state    = drop_state_r;
  assign bus.pkt_drop      = pkt_drop_r;
  assign bus.dest_addr     = dest_addr;

endmodule

// File: tb/tb_router_fsm_np.sv
// tb_router_fsm_np: directed bench for router_fsm_np. Each scenario drives
// inputs cycle by cycle and queues the state the controller must be in
// after the next edge; the compare process turns that into the expected
// strobe vector and checks it every cycle. A second 5-port instance covers
// async reset and wide-address drop.
module tb_router_fsm_np;

  typedef enum int {E_DA, E_WTE, E_LFD, E_LD, E_FFS, E_LAF, E_LP, E_CPE, E_DROP} exp_t;
  typedef struct {
    exp_t       st;
    logic [1:0] dest;
  } exp_item_t;

  logic clock = 1'b0;
  logic reset_a, reset_b;
  always #5 clock = ~clock;

  router_fsm_np_if #(.NUM_PORTS(3)) ia ();
  router_fsm_np_if #(.NUM_PORTS(5)) ib ();

  router_fsm_np #(.NUM_PORTS(3), .WAIT_TIMEOUT(8)) dut_a (
    .clock (clock),
    .reset (reset_a),
    .bus   (ia.slave)
  );

  router_fsm_np #(.NUM_PORTS(5)) dut_b (
    .clock (clock),
    .reset (reset_b),
    .bus   (ib.slave)
  );

  int checks = 0;
  int failures = 0;
  int wen_cnt = 0, drop_cnt = 0, wte_cnt = 0, ffs_cnt = 0;
  int cyc = 0;
  exp_item_t q[$];
  exp_t prev_st = E_DA;
  exp_item_t cmp_it;
  logic [9:0] cmp_exp;

  // {detect, lfd, ld, laf, full, rst_int, wen, busy, drop, pkt_drop}
  logic [9:0] va, vb;
  assign va = {ia.detect_add, ia.lfd_state, ia.ld_state, ia.laf_state, ia.full_state,
               ia.rst_int_reg, ia.write_enb_reg, ia.busy, ia.drop_state, ia.pkt_drop};
  assign vb = {ib.detect_add, ib.lfd_state, ib.ld_state, ib.laf_state, ib.full_state,
               ib.rst_int_reg, ib.write_enb_reg, ib.busy, ib.drop_state, ib.pkt_drop};

  function automatic logic [9:0] strobes_for(input exp_t s, input exp_t p);
    logic [9:0] v;
    v = '0;
    case (s)
      E_DA:   v[9] = 1'b1;
      E_WTE:  v[2] = 1'b1;
      E_LFD:  begin v[8] = 1'b1; v[2] = 1'b1; end
      E_LD:   begin v[7] = 1'b1; v[3] = 1'b1; end
      E_FFS:  begin v[5] = 1'b1; v[2] = 1'b1; end
      E_LAF:  begin v[6] = 1'b1; v[3] = 1'b1; v[2] = 1'b1; end
      E_LP:   begin v[3] = 1'b1; v[2] = 1'b1; end
      E_CPE:  begin v[4] = 1'b1; v[2] = 1'b1; end
      E_DROP: begin v[1] = 1'b1; v[0] = (p != E_DROP); end
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      cmp_it  = q.pop_front();
      cmp_exp = strobes_for(cmp_it.st, prev_st);
      checks++;
      cyc++;
      if (va !== cmp_exp || ia.dest_addr !== cmp_it.dest) begin
        failures++;
        $display("FAIL step%0d_%s strobes act=%b exp=%b dest act=%0d exp=%0d",
                 cyc, cmp_it.st.name(), va, cmp_exp, ia.dest_addr, cmp_it.dest);
      end
      prev_st = cmp_it.st;
      wen_cnt  += int'(ia.write_enb_reg);
      drop_cnt += int'(ia.pkt_drop);
      ffs_cnt  += int'(ia.full_state);
      wte_cnt  += int'(ia.busy && !ia.lfd_state && !ia.full_state && !ia.laf_state &&
                       !ia.write_enb_reg && !ia.rst_int_reg);
    end
  end

  task automatic step(input exp_t s, input logic [1:0] d);
    exp_item_t it;
    it.st = s;
    it.dest = d;
    q.push_back(it);
    @(negedge clock);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    wen_cnt = 0;
    drop_cnt = 0;
    wte_cnt = 0;
    ffs_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    ia.pkt_valid = 0; ia.data_in = '0; ia.fifo_full = 0; ia.fifo_empty = 3'b111;
    ia.soft_reset = '0; ia.parity_done = 0; ia.low_pkt_valid = 0;
    ib.pkt_valid = 0; ib.data_in = '0; ib.fifo_full = 0; ib.fifo_empty = 5'b11111;
    ib.soft_reset = '0; ib.parity_done = 0; ib.low_pkt_valid = 0;
    repeat (2) @(negedge clock);

    chk("rst_a_strobes", int'(va), 'h200);
    chk("rst_a_dest", int'(ia.dest_addr), 0);
    chk("rst_b_strobes", int'(vb), 'h200);
    reset_a = 1'b0;
    reset_b = 1'b0;

    // Packet to port 1, empty FIFO, 4 payload bytes then parity.
    clear_counts();
    ia.pkt_valid = 1; ia.data_in = 2'd1; step(E_LFD, 1);
    step(E_LD, 1); step(E_LD, 1); step(E_LD, 1); step(E_LD, 1);
    ia.pkt_valid = 0; step(E_LP, 1);
    step(E_CPE, 1);
    step(E_DA, 1);
    chk("pkt1_wen_cycles", wen_cnt, 5);

    // Invalid address 3 on a 3-port router.
    clear_counts();
    ia.pkt_valid = 1; ia.data_in = 2'd3; step(E_DROP, 3);
    step(E_DROP, 3); step(E_DROP, 3);
    ia.pkt_valid = 0; step(E_DA, 3);
    step(E_DA, 3);
    chk("drop_pulses", drop_cnt, 1);
    chk("drop_wen_cycles", wen_cnt, 0);

    // Port 2 busy for 5 wait cycles, then drains.
    clear_counts();
    ia.fifo_empty = 3'b011;
    ia.pkt_valid = 1; ia.data_in = 2'd2; step(E_WTE, 2);
    repeat (4) step(E_WTE, 2);
    ia.fifo_empty = 3'b111; step(E_LFD, 2);
    step(E_LD, 2);
    ia.pkt_valid = 0; step(E_LP, 2);
    step(E_CPE, 2);
    step(E_DA, 2);
    chk("wait5_wte_cycles", wte_cnt, 5);
    chk("wait5_drops", drop_cnt, 0);

    // Port 2 never drains: timeout after 8 wait cycles.
    clear_counts();
    ia.fifo_empty = 3'b011;
    ia.pkt_valid = 1; ia.data_in = 2'd2; step(E_WTE, 2);
    repeat (7) step(E_WTE, 2);
    step(E_DROP, 2);
    step(E_DROP, 2);
    ia.pkt_valid = 0; step(E_DA, 2);
    ia.fifo_empty = 3'b111; step(E_DA, 2);
    chk("timeout_wte_cycles", wte_cnt, 8);
    chk("timeout_drops", drop_cnt, 1);

    // FIFO full on the 3rd payload byte for 4 cycles, then full after parity.
    clear_counts();
    ia.pkt_valid = 1; ia.data_in = 2'd0; step(E_LFD, 0);
    step(E_LD, 0); step(E_LD, 0);
    ia.fifo_full = 1; step(E_FFS, 0);
    step(E_FFS, 0); step(E_FFS, 0); step(E_FFS, 0);
    ia.fifo_full = 0; step(E_LAF, 0);
    step(E_LD, 0);
    chk("full_ffs_cycles", ffs_cnt, 4);
    ia.pkt_valid = 0; step(E_LP, 0);
    ia.fifo_full = 1; step(E_CPE, 0);
    step(E_FFS, 0);
    ia.fifo_full = 0; step(E_LAF, 0);
    ia.parity_done = 1; step(E_DA, 0);
    ia.parity_done = 0; step(E_DA, 0);

    // Soft reset: other port ignored, own port returns to decode.
    ia.pkt_valid = 1; ia.data_in = 2'd1; step(E_LFD, 1);
    step(E_LD, 1);
    ia.soft_reset = 3'b001; step(E_LD, 1);
    ia.soft_reset = 3'b010; step(E_DA, 1);
    ia.soft_reset = 3'b000; ia.pkt_valid = 0; step(E_DA, 1);

    // 5-port instance: address 4, async reset mid-load, then address 5 drop.
    ib.pkt_valid = 1; ib.data_in = 3'd4; @(negedge clock);
    chk("b_lfd_strobes", int'(vb), 'h104);
    chk("b_dest4", int'(ib.dest_addr), 4);
    @(negedge clock);
    chk("b_ld_strobes", int'(vb), 'h088);
    #2 reset_b = 1'b1;
    #1;
    chk("b_async_rst_strobes", int'(vb), 'h200);
    chk("b_async_rst_dest", int'(ib.dest_addr), 0);
    @(negedge clock);
    reset_b = 1'b0;
    ib.data_in = 3'd5;
    @(negedge clock);
    chk("b_drop_strobes", int'(vb), 'h003);
    chk("b_drop_dest", int'(ib.dest_addr), 5);
    ib.pkt_valid = 0;
    @(negedge clock);
    chk("b_drop_exit_strobes", int'(vb), 'h200);

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_fsm_np.md
# router_fsm_np

Parametrised packet-router control FSM for an N-output router. It sits between the input byte stream and the N output FIFOs, and sequences header decode, payload and parity loading, FIFO-full back-pressure and parity check. It steers the register/synchroniser blocks through state strobes. Beyond the 3-port controller, it adds:
- a configurable port count;
- a real wait-till-empty state with a timeout;
- invalid-address and timeout packet drop;
- per-destination soft reset.

## Interface
- NUM_PORTS, 3, number of output FIFOs (2..16)
- ADDR_W, $clog2(NUM_PORTS), header address field width (data_in[ADDR_W-1:0])
- WAIT_TIMEOUT, 64, max cycles in WAIT_TILL_EMPTY before drop; 0 disables the timeout
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pkt_valid  in  1  source byte valid; deasserts on the parity byte
- data_in  in  ADDR_W  address field of the current byte
- fifo_full  in  1  full flag of the selected destination FIFO
- fifo_empty  in  NUM_PORTS  per-FIFO empty flags
- soft_reset  in  NUM_PORTS  per-FIFO soft reset (read timeout)
- parity_done  in  1  parity byte has been written
- low_pkt_valid  in  1  pkt_valid fell while in the full path
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  state strobes
- write_enb_reg  out  1  FIFO write enable
- busy  out  1  stall source
- drop_state  out  1  bytes being discarded
- pkt_drop  out  1  one-cycle pulse on entry to DROP_PACKET
- dest_addr  out  ADDR_W  latched destination

## Operation
States: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, DROP_PACKET.

- **DECODE_ADDRESS:** detect_add=1.
  - If pkt_valid: latch dest_addr<=data_in.
  - If data_in>=NUM_PORTS -> DROP_PACKET.
  - Else if fifo_empty[data_in] -> LOAD_FIRST_DATA.
  - Else -> WAIT_TILL_EMPTY.
  - Otherwise stay.
- **WAIT_TILL_EMPTY:** busy=1; wait counter cleared on entry, incremented each cycle.
  - If fifo_empty[dest_addr] -> LOAD_FIRST_DATA.
  - Else if WAIT_TIMEOUT!=0 and count==WAIT_TIMEOUT-1 -> DROP_PACKET.
  - Empty has priority over timeout.
- **LOAD_FIRST_DATA:** lfd_state=1, busy=1 -> LOAD_DATA.
- **LOAD_DATA:** ld_state=1, write_enb_reg=1.
  - If fifo_full -> FIFO_FULL_STATE (full has priority).
  - Else if !pkt_valid -> LOAD_PARITY.
  - Else stay.
- **FIFO_FULL_STATE:** full_state=1, busy=1. Stay while fifo_full, else -> LOAD_AFTER_FULL.
- **LOAD_AFTER_FULL:** laf_state=1, busy=1, write_enb_reg=1.
  - If parity_done -> DECODE_ADDRESS.
  - Else if low_pkt_valid -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- **LOAD_PARITY:** busy=1, write_enb_reg=1 -> CHECK_PARITY_ERROR.
- **CHECK_PARITY_ERROR:** rst_int_reg=1, busy=1. If fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- **DROP_PACKET:** drop_state=1, busy=0, write_enb_reg=0. Stay while pkt_valid; on !pkt_valid -> DECODE_ADDRESS. The parity byte is consumed with no write.
- **Soft reset:** soft_reset[dest_addr]=1 in any state except DECODE_ADDRESS -> DECODE_ADDRESS next cycle. Soft resets on other ports are ignored.
- **Priority:** reset > soft reset > normal transition.
- Every strobe not listed for a state is 0.
- Unreachable state encodings -> DECODE_ADDRESS.

## Timing
- On reset: state=DECODE_ADDRESS and dest_addr=0. Resulting outputs: detect_add=1, all other outputs 0.
- Strobes are Moore decodes of the registered state; no input-to-output combinational path.
- pkt_drop is registered; it is high for exactly the first DROP_PACKET cycle.
- Header-to-first-write latency: 2 cycles when the FIFO is empty (DA -> LFD -> LD). With a wait, it is k+2 cycles, where k is the number of WAIT_TILL_EMPTY cycles.
- dest_addr updates only in DECODE_ADDRESS with pkt_valid; it is stable for the remainder of the packet.
- The wait counter has width $clog2(WAIT_TIMEOUT+1) and saturates; it never wraps.
- Timeout drop occurs after exactly WAIT_TIMEOUT cycles in WAIT_TILL_EMPTY.

## Structure
- router_pkg holds:
  - the state enum router_state_t (4-bit encoding);
  - function addr_w(n)=$clog2(n);
  - the constant ROUTER_MAX_PORTS=16.
- Sub-module router_wait_timer holds the parametrised clear/enable/saturating counter, with a done output. The FSM instantiates it for WAIT_TILL_EMPTY.

## Test plan
- NUM_PORTS=3, header addr=1, fifo_empty=3'b111, 4 payload bytes -> state sequence DA,LFD,LD×4,LP,CPE,DA; write_enb_reg high for 5 cycles (4 payload + parity); dest_addr=1.
- NUM_PORTS=3, header addr=3 -> pkt_drop pulses once; write_enb_reg stays 0 for the whole packet; DA after pkt_valid falls.
- WAIT_TIMEOUT=8, fifo_empty[2]=0 for 5 cycles then 1 -> WTE for 5 cycles, then LFD, no drop. Holding fifo_empty[2]=0 instead -> DROP_PACKET after 8 cycles.
- fifo_full asserted on the 3rd payload byte for 4 cycles -> FFS for 4 cycles, then LAF, then LD (low_pkt_valid=0); busy=1 throughout FFS/LAF.
- Mid-packet soft_reset[dest]=1 -> DA next cycle. soft_reset on another port -> no effect.
- NUM_PORTS=5, addr=4, plus async reset asserted mid-LD -> immediate DA, detect_add=1, dest_addr=0, all other strobes 0.
